// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB data memory slave.
package apb_mem_pkg;

    typedef enum logic {IDLE, ACCESS} apb_state_t;

    localparam int CNT_W = 4;

    // Number of byte lanes for a given data width.
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sp_ram_bytewe.sv
// Single-port RAM with per-byte write enables and a registered read port.
module sp_ram_bytewe #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Byte-lane write; lanes with be=0 keep their contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read output; cleared by reset, memory array is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/apb_data_mem_slave.sv
// APB4 slave data memory with byte strobes, wait states and an
// out-of-range error response.
module apb_data_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                        pclk,
    input  logic                        prst,
    input  logic [ADDR_W-1:0]           paddr,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [DATA_W-1:0]           pwdata,
    input  logic [strb_w(DATA_W)-1:0]   pstrb,
    output logic [DATA_W-1:0]           prdata,
    output logic                        pready,
    output logic                        pslverr
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $fatal(1, "apb_data_mem_slave: DATA_W must be a multiple of 8");
    end
    if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $fatal(1, "apb_data_mem_slave: DEPTH exceeds 2**ADDR_W");
    end
    if (WAIT_STATES > 15) begin : g_bad_wait
        $fatal(1, "apb_data_mem_slave: WAIT_STATES must be 0..15");
    end

    apb_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              addr_oob;
    logic              ram_re;
    logic              ram_we;

    assign addr_oob = (32'(paddr) >= 32'(DEPTH));

    // Read is launched on the SETUP edge so data is ready for the first ACCESS cycle.
    assign ram_re = (state == IDLE) && psel && !pwrite && !addr_oob;

    // Reset wins over a write completing on the same edge.
    assign ram_we = pready && pwrite && !err_q && !prst;

    // Transfer sequencing: IDLE/ACCESS state, wait counter and error flag.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel) begin
                        state <= ACCESS;
                        cnt   <= CNT_W'(WAIT_STATES);
                        err_q <= addr_oob;
                    end
                end
                ACCESS: begin
                    if (psel && penable) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion and response gating.
    always_comb begin
        pready  = (state == ACCESS) && (cnt == '0) && psel && penable;
        pslverr = pready && err_q;
        prdata  = (pready && !pwrite && !err_q) ? rdata_q : '0;
    end

    sp_ram_bytewe #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (pclk),
        .rst   (prst),
        .we    (ram_we),
        .be    (pstrb),
        .re    (ram_re),
        .addr  (paddr[RAM_AW-1:0]),
        .wdata (pwdata),
        .rdata (rdata_q)
    );

endmodule
